except_resolve: RTL and testbench
=================================

// Module: except_resolve
// PURPOSE
// - Downstream of the FPU exception classifier.
// - Consumes the classifier's registered flags, which arrive EXC_LAT cycles after the operands.
// - Internally aligns the opcode, signs and valid with those flags, then produces:
//   - the special-case result (NaN/Inf/Zero override) and per-op invalid / div-by-zero flags;
//   - sticky status flags and a saturating special-result counter.
// - Its output feeds the final result mux, which selects between out_result and the datapath result.
// PARAMETERS
// - EXC_LAT  2   cycles from operand presentation to classifier flag valid
// - CNT_W    16  width of the special-result counter
// PORTS
// - clk              in   1      clock, all state on rising edge
// - rst_n            in   1      synchronous reset, active low
// - in_valid         in   1      operands presented to the classifier this cycle (T)
// - in_op            in   2      0=add, 1=sub, 2=mul, 3=div; sampled at T
// - in_sign_a        in   1      opa[31], sampled at T
// - in_sign_b        in   1      opb[31], sampled at T
// - snan, ind        in   1      classifier flags, valid at T+EXC_LAT
// - opa_nan, opb_nan in   1      classifier flags, valid at T+EXC_LAT
// - opa_inf, opb_inf in   1      classifier flags, valid at T+EXC_LAT
// - opa_00, opb_00   in   1      classifier flags, valid at T+EXC_LAT
// - flags_clr        in   1      clear sticky flags and counter
// - out_valid        out  1      result for the op presented at T; asserted at T+EXC_LAT+1
// - out_special      out  1      out_result overrides the datapath result
// - out_result       out  32     special result; 0 when out_special=0
// - out_invalid      out  1      IEEE invalid raised by this op
// - out_div_zero     out  1      IEEE div-by-zero raised by this op
// - sticky_invalid   out  1      OR of out_invalid since the last clear
// - sticky_div_zero  out  1      OR of out_div_zero since the last clear
// - special_cnt      out  CNT_W  count of out_special results, saturating
// BEHAVIOUR
// - Reset: every output and internal pipeline register is 0. In-flight ops are dropped; no out_valid for them.
// - Alignment: valid, op and signs pass through an EXC_LAT-deep shift register, so they meet the flags at T+EXC_LAT.
// - Output register: resolution is combinational on the aligned signals and registered once. Total latency is EXC_LAT+1; throughput is one op per cycle with no backpressure.
// - Aligned valid = 0: out_valid, out_special, out_invalid and out_div_zero are 0, and out_result is 0.
// - Resolution rules (first match wins). Notation: sa/sb are the aligned signs; sx = sa^sb.
//   1. opa_nan|opb_nan: result 0x7FC00000; invalid = snan.
//   2. add with ind and sa!=sb, or sub with ind and sa==sb: 0x7FC00000, invalid.
//   3. mul with (opa_inf&opb_00)|(opb_inf&opa_00): 0x7FC00000, invalid.
//   4. div with ind, or with opa_00&opb_00: 0x7FC00000, invalid.
//   5. div with opb_00 (opa finite and nonzero): {sx,8'hFF,23'h0}, div_zero.
//   6. add/sub with opa_inf: {sa,8'hFF,23'h0}.
//   7. add/sub with opb_inf: {sb^(op==sub),8'hFF,23'h0}.
//   8. mul/div with opa_inf, or mul with opb_inf: {sx,8'hFF,23'h0}.
//   9. div with opb_inf: {sx,31'h0}.
//   - Any rule matched: out_special=1. No match: out_special=0 and out_result=0.
// - Sticky flags: sticky_x <= (flags_clr ? 0 : sticky_x) | (out_valid_next & x_next).
//   - A flag raised in the clear cycle survives the clear.
// - Counter: special_cnt increments when a registered special result is produced.
//   - Holds at 2^CNT_W-1.
//   - flags_clr together with a special result loads 1.
// - Denormal operands are not special here; the datapath handles them.
// TESTING
// - Reset mid-stream: in_valid=1 at T, rst_n=0 at T+1 -> no out_valid at T+3; all outputs 0.
// - add +Inf + -Inf (0x7F800000, 0xFF800000) -> at T+3: out_result=0x7FC00000, out_invalid=1, out_special=1.
// - sub -Inf - 0x3F800000 -> out_result=0xFF800000, invalid=0. sub 0x3F800000 - +Inf -> 0xFF800000.
// - div 0xBF800000 / 0x00000000 -> 0xFF800000, out_div_zero=1. div 0/0 -> 0x7FC00000, invalid=1.
// - mul with opa=0x7F800001 (sNaN), opb=1.0 -> 0x7FC00000, invalid=1; qNaN 0x7FC00001 -> invalid=0.
// - Back-to-back ops each cycle: results appear in order, one per cycle, with no bubbles.
// - Sticky/counter: flags_clr coincides with a new invalid -> sticky_invalid=1, special_cnt=1.
// - Sticky/counter: saturate with CNT_W=2 -> the counter holds at 3.

Source files
------------

// File: rtl/except_resolve.sv
// except_resolve: aligns opcode/signs/valid with the FPU exception classifier
// flags, resolves the IEEE special-case result and exception flags, and keeps
// sticky status flags plus a saturating count of special results.
module except_resolve #(
    parameter int EXC_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       in_op,
    input  logic             in_sign_a,
    input  logic             in_sign_b,
    input  logic             snan,
    input  logic             ind,
    input  logic             opa_nan,
    input  logic             opb_nan,
    input  logic             opa_inf,
    input  logic             opb_inf,
    input  logic             opa_00,
    input  logic             opb_00,
    input  logic             flags_clr,
    output logic             out_valid,
    output logic             out_special,
    output logic [31:0]      out_result,
    output logic             out_invalid,
    output logic             out_div_zero,
    output logic             sticky_invalid,
    output logic             sticky_div_zero,
    output logic [CNT_W-1:0] special_cnt
);

    localparam logic [1:0]       OP_ADD  = 2'd0;
    localparam logic [1:0]       OP_SUB  = 2'd1;
    localparam logic [1:0]       OP_MUL  = 2'd2;
    localparam logic [1:0]       OP_DIV  = 2'd3;
    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [EXC_LAT-1:0]      vld_pipe;
    logic [EXC_LAT-1:0][1:0] op_pipe;
    logic [EXC_LAT-1:0]      sa_pipe;
    logic [EXC_LAT-1:0]      sb_pipe;

    logic        v, sa, sb, sx, is_as;
    logic [1:0]  op;
    logic        sp_next, inv_next, dz_next;
    logic [31:0] res_next;

    // Delay valid/op/signs so they line up with the classifier's flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            op_pipe  <= '0;
            sa_pipe  <= '0;
            sb_pipe  <= '0;
        end else begin
            vld_pipe[0] <= in_valid;
            op_pipe[0]  <= in_op;
            sa_pipe[0]  <= in_sign_a;
            sb_pipe[0]  <= in_sign_b;
            for (int i = 1; i < EXC_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                op_pipe[i]  <= op_pipe[i-1];
                sa_pipe[i]  <= sa_pipe[i-1];
                sb_pipe[i]  <= sb_pipe[i-1];
            end
        end
    end

    assign v     = vld_pipe[EXC_LAT-1];
    assign op    = op_pipe[EXC_LAT-1];
    assign sa    = sa_pipe[EXC_LAT-1];
    assign sb    = sb_pipe[EXC_LAT-1];
    assign sx    = sa ^ sb;
    assign is_as = (op == OP_ADD) || (op == OP_SUB);

    // Priority resolution of the special result; inf/0 is left to the
    // infinity rule so it yields a signed infinity without div-by-zero.
    always_comb begin
        sp_next  = 1'b0;
        res_next = 32'h0;
        inv_next = 1'b0;
        dz_next  = 1'b0;
        if (v) begin
            if (opa_nan || opb_nan) begin
                sp_next = 1'b1; res_next = QNAN; inv_next = snan;
            end else if ((op == OP_ADD && ind && (sa != sb)) ||
                         (op == OP_SUB && ind && (sa == sb))) begin
                sp_next = 1'b1; res_next = QNAN; inv_next = 1'b1;
            end else if (op == OP_MUL && ((opa_inf && opb_00) || (opb_inf && opa_00))) begin
                sp_next = 1'b1; res_next = QNAN; inv_next = 1'b1;
            end else if (op == OP_DIV && (ind || (opa_00 && opb_00))) begin
                sp_next = 1'b1; res_next = QNAN; inv_next = 1'b1;
            end else if (op == OP_DIV && opb_00 && !opa_inf) begin
                sp_next = 1'b1; res_next = {sx, 8'hFF, 23'h0}; dz_next = 1'b1;
            end else if (is_as && opa_inf) begin
                sp_next = 1'b1; res_next = {sa, 8'hFF, 23'h0};
            end else if (is_as && opb_inf) begin
                sp_next = 1'b1; res_next = {sb ^ (op == OP_SUB), 8'hFF, 23'h0};
            end else if (((op == OP_MUL || op == OP_DIV) && opa_inf) ||
                         (op == OP_MUL && opb_inf)) begin
                sp_next = 1'b1; res_next = {sx, 8'hFF, 23'h0};
            end else if (op == OP_DIV && opb_inf) begin
                sp_next = 1'b1; res_next = {sx, 31'h0};
            end
        end
    end

    // Output register, sticky flags and saturating special-result counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            out_special     <= 1'b0;
            out_result      <= 32'h0;
            out_invalid     <= 1'b0;
            out_div_zero    <= 1'b0;
            sticky_invalid  <= 1'b0;
            sticky_div_zero <= 1'b0;
            special_cnt     <= '0;
        end else begin
            out_valid       <= v;
            out_special     <= sp_next;
            out_result      <= res_next;
            out_invalid     <= inv_next;
            out_div_zero    <= dz_next;
            sticky_invalid  <= (flags_clr ? 1'b0 : sticky_invalid) | inv_next;
            sticky_div_zero <= (flags_clr ? 1'b0 : sticky_div_zero) | dz_next;
            if (flags_clr)
                special_cnt <= sp_next ? CNT_W'(1) : '0;
            else if (sp_next && special_cnt != CNT_MAX)
                special_cnt <= special_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_except_resolve.sv
// Scoreboard bench for except_resolve: IEEE-level reference model on real
// float operands, classifier flags driven EXC_LAT cycles after the operands.
module tb_except_resolve;

    localparam int EXC_LAT = 2;
    localparam int CNT_W   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic [1:0] in_op = 2'd0;
    logic in_sign_a = 1'b0, in_sign_b = 1'b0;
    logic snan = 1'b0, ind = 1'b0, opa_nan = 1'b0, opb_nan = 1'b0;
    logic opa_inf = 1'b0, opb_inf = 1'b0, opa_00 = 1'b0, opb_00 = 1'b0;
    logic flags_clr = 1'b0;
    logic out_valid, out_special, out_invalid, out_div_zero;
    logic sticky_invalid, sticky_div_zero;
    logic [31:0] out_result;
    logic [CNT_W-1:0] special_cnt;

    except_resolve #(.EXC_LAT(EXC_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_op(in_op),
        .in_sign_a(in_sign_a), .in_sign_b(in_sign_b),
        .snan(snan), .ind(ind), .opa_nan(opa_nan), .opb_nan(opb_nan),
        .opa_inf(opa_inf), .opb_inf(opb_inf), .opa_00(opa_00), .opb_00(opb_00),
        .flags_clr(flags_clr), .out_valid(out_valid), .out_special(out_special),
        .out_result(out_result), .out_invalid(out_invalid), .out_div_zero(out_div_zero),
        .sticky_invalid(sticky_invalid), .sticky_div_zero(sticky_div_zero),
        .special_cnt(special_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        sp, inv, dz;
        int          due;
    } exp_t;

    exp_t q[$];
    int checks = 0, fails = 0, cyc = 0;
    logic [31:0] h1a = 0, h1b = 0, h2a = 0, h2b = 0, ca = 0, cb = 0;

    function automatic bit is_nan(input logic [31:0] x);
        return x[30:23] == 8'hFF && x[22:0] != 0;
    endfunction
    function automatic bit is_inf(input logic [31:0] x);
        return x[30:23] == 8'hFF && x[22:0] == 0;
    endfunction
    function automatic bit is_zero(input logic [31:0] x);
        return x[30:0] == 0;
    endfunction

    // IEEE-754 special-case semantics for a+b, a-b, a*b, a/b.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t m;
        bit ai = is_inf(a), bi = is_inf(b), az = is_zero(a), bz = is_zero(b);
        bit sx = a[31] ^ b[31];
        m.res = 0; m.sp = 0; m.inv = 0; m.dz = 0; m.due = 0;
        if (is_nan(a) || is_nan(b)) begin
            m.sp = 1; m.res = 32'h7FC00000;
            m.inv = (is_nan(a) && !a[22]) || (is_nan(b) && !b[22]);
        end else if (op <= 2'd1) begin
            bit bs = b[31] ^ (op == 2'd1);   // sign of b as actually added
            if (ai && bi && (a[31] != bs)) begin m.sp = 1; m.res = 32'h7FC00000; m.inv = 1; end
            else if (ai) begin m.sp = 1; m.res = {a[31], 8'hFF, 23'h0}; end
            else if (bi) begin m.sp = 1; m.res = {bs, 8'hFF, 23'h0}; end
        end else if (op == 2'd2) begin
            if ((ai && bz) || (bi && az)) begin m.sp = 1; m.res = 32'h7FC00000; m.inv = 1; end
            else if (ai || bi) begin m.sp = 1; m.res = {sx, 8'hFF, 23'h0}; end
        end else begin
            if ((ai && bi) || (az && bz)) begin m.sp = 1; m.res = 32'h7FC00000; m.inv = 1; end
            else if (ai) begin m.sp = 1; m.res = {sx, 8'hFF, 23'h0}; end
            else if (bz) begin m.sp = 1; m.res = {sx, 8'hFF, 23'h0}; m.dz = 1; end
            else if (bi) begin m.sp = 1; m.res = {sx, 31'h0}; end
        end
        return m;
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] r = $urandom;
        logic s = r[31];
        case ($urandom % 7)
            0: return {s, 31'h0};
            1: return {s, 8'hFF, 23'h0};
            2: return {s, 8'hFF, 1'b1, r[21:0]};
            3: return {s, 8'hFF, 1'b0, r[21:1], 1'b1};
            4, 5: return {s, 8'($urandom_range(1, 254)), r[22:0]};
            default: return {s, 8'h00, r[22:1], 1'b1};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle: operands for this op, classifier flags for the op EXC_LAT back.
    task automatic step(input bit v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit clr = 1'b0, input bit rn = 1'b1);
        exp_t e;
        @(negedge clk);
        h2a = h1a; h2b = h1b; h1a = ca; h1b = cb; ca = a; cb = b;
        rst_n = rn; in_valid = v; in_op = op; in_sign_a = a[31]; in_sign_b = b[31]; flags_clr = clr;
        opa_nan = is_nan(h2a); opb_nan = is_nan(h2b);
        opa_inf = is_inf(h2a); opb_inf = is_inf(h2b);
        opa_00 = is_zero(h2a); opb_00 = is_zero(h2b);
        snan = (is_nan(h2a) && !h2a[22]) || (is_nan(h2b) && !h2b[22]);
        ind = is_inf(h2a) && is_inf(h2b);
        if (v && rn) begin
            e = model(op, a, b);
            e.due = cyc + 1 + EXC_LAT;
            q.push_back(e);
        end
    endtask

    // Monitor: pop expected results as the DUT presents them; track sticky/count.
    initial begin
        bit clr_s, rs, ni, nd, ns;
        bit st_i = 0, st_d = 0;
        int cnt = 0;
        exp_t e;
        forever begin
            @(posedge clk);
            clr_s = flags_clr; rs = rst_n; cyc++;
            #1;
            if (!rs) begin
                q.delete(); st_i = 0; st_d = 0; cnt = 0;
                chk("reset out_valid", 32'(out_valid), 0);
                chk("reset out_special", 32'(out_special), 0);
                chk("reset out_result", out_result, 0);
                chk("reset flags", {29'h0, out_invalid, out_div_zero, sticky_invalid}, 0);
                chk("reset sticky_dz/cnt", {29'h0, sticky_div_zero, special_cnt}, 0);
            end else begin
                ni = 0; nd = 0; ns = 0;
                while (q.size() > 0 && q[0].due < cyc) begin
                    checks++; fails++;
                    $display("FAIL latency: result due cycle %0d absent, now %0d", q[0].due, cyc);
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    chk("out_valid", 32'(out_valid), 1);
                    chk("out_result", out_result, e.res);
                    chk("out_special", 32'(out_special), 32'(e.sp));
                    chk("out_invalid", 32'(out_invalid), 32'(e.inv));
                    chk("out_div_zero", 32'(out_div_zero), 32'(e.dz));
                    ni = e.inv; nd = e.dz; ns = e.sp;
                end else begin
                    chk("idle out_valid", 32'(out_valid), 0);
                    chk("idle outputs", {out_result[31:3], out_special, out_invalid, out_div_zero}, 0);
                end
                st_i = (clr_s ? 1'b0 : st_i) | ni;
                st_d = (clr_s ? 1'b0 : st_d) | nd;
                if (clr_s) cnt = ns ? 1 : 0;
                else if (ns && cnt < (1 << CNT_W) - 1) cnt = cnt + 1;
                chk("sticky_invalid", 32'(sticky_invalid), 32'(st_i));
                chk("sticky_div_zero", 32'(sticky_div_zero), 32'(st_d));
                chk("special_cnt", 32'(special_cnt), 32'(cnt));
            end
        end
    end

    initial begin
        logic [1:0] op;
        logic [31:0] a, b;
        repeat (3) step(0, 0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        // In-flight op dropped by a reset the next cycle.
        step(1, 2'd0, 32'h7F800000, 32'hFF800000);
        step(0, 0, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        // Directed special cases, issued back to back.
        step(1, 2'd0, 32'h7F800000, 32'hFF800000);
        step(1, 2'd1, 32'hFF800000, 32'h3F800000);
        step(1, 2'd1, 32'h3F800000, 32'h7F800000);
        step(1, 2'd3, 32'hBF800000, 32'h00000000);
        step(1, 2'd3, 32'h00000000, 32'h00000000);
        step(1, 2'd2, 32'h7F800001, 32'h3F800000);
        step(1, 2'd2, 32'h7FC00001, 32'h3F800000);
        step(1, 2'd3, 32'h3F800000, 32'hFF800000);
        step(1, 2'd2, 32'h00000001, 32'h3F800000);
        // Clear coinciding with a fresh invalid result.
        step(1, 2'd0, 32'h7F800000, 32'hFF800000);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0);
        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            op = 2'($urandom);
            a = rand_operand();
            b = rand_operand();
            if (op == 2'd3 && is_inf(a) && is_zero(b)) b = 32'h3F800000;
            step(($urandom % 4) != 0, op, a, b, ($urandom % 20) == 0);
        end
        repeat (EXC_LAT + 3) step(0, 0, 0, 0);
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results never appeared, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
